lsu_mem_port: RTL and testbench
===============================

LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 Parameter TIMEOUT, default 16, max cycles WAIT holds for a memory valid before faulting.
REQ-002 clk  in  1  system clock; single clock domain.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 i_req  in  1  core request strobe; sampled only in IDLE.
REQ-005 i_we  in  1  1=store, 0=load.
REQ-006 i_funct3  in  3  RV32 size/sign: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
REQ-007 i_addr  in  32  byte address.
REQ-008 i_wdata  in  32  store data, right-justified.
REQ-009 o_busy  out  1  high in every state except IDLE.
REQ-010 o_done  out  1  one-cycle completion pulse.
REQ-011 o_rdata  out  32  extended load result; held until next o_done.
REQ-012 o_err  out  1  one-cycle pulse: misaligned access or timeout.
REQ-013 o_mem_rd / o_mem_wr  out  1 each  one-cycle memory request strobes.
REQ-014 o_mem_addr  out  32  word-aligned address ({i_addr[31:2],2'b00}).
REQ-015 o_mem_wrmask  out  4  byte-lane mask, already positioned by i_addr[1:0].
REQ-016 o_mem_data  out  32  store data shifted to its byte lanes (i_wdata << 8*i_addr[1:0]).
REQ-017 i_mem_rd_valid / i_mem_wr_valid  in  1 each  memory completion.
REQ-018 i_mem_data  in  32  full word read from o_mem_addr.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT; all outputs registered.
REQ-020 IDLE + i_req + aligned -> ISSUE; latch addr, we, funct3, lane data, mask.
REQ-021 Misaligned = half with addr[0]=1, or word with addr[1:0]!=0; result: o_err pulse next cycle, no memory strobe, remain IDLE.
REQ-022 Undefined funct3 (011, 110, 111, or 100/101 with i_we=1) shall be treated as misaligned.
REQ-023 ISSUE: exactly one of o_mem_rd/o_mem_wr high for one cycle, then WAIT; timeout counter cleared.
REQ-024 Masks: byte 0001, half 0011, word 1111, each shifted left by addr[1:0]; o_mem_wrmask=0 on loads.
REQ-025 WAIT: matching valid (rd for load, wr for store) -> o_done next cycle, back to IDLE; the non-matching valid is ignored.
REQ-026 Load result: lane = i_mem_data >> 8*addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged; captured on the valid cycle.
REQ-027 Stores do not modify o_rdata.
REQ-028 Counter increments each WAIT cycle; at TIMEOUT without valid: o_err pulse, IDLE, o_rdata unchanged.
REQ-029 Valid arriving in the same cycle the counter reaches TIMEOUT counts as success.
REQ-030 i_req while o_busy shall be ignored; no queuing.
REQ-031 Latency with a one-cycle-registered memory: i_req cycle 0, strobe cycle 1, valid cycle 2, o_done cycle 3.
REQ-032 o_mem_addr/data/wrmask stable from ISSUE through the end of WAIT.

Reset
REQ-033 rst forces IDLE, counter 0, and o_busy, o_done, o_err, o_mem_rd, o_mem_wr, o_mem_wrmask to 0; o_rdata, o_mem_addr, o_mem_data to 32'h0.
REQ-034 rst mid-transaction aborts with no o_done or o_err; memory valids arriving after reset are ignored.

Structure
REQ-035 Package lsu_pkg holds funct3 constants, FSM state enum, and byte-mask constants.
REQ-036 Sub-module lsu_lane (combinational): lane extraction and sign/zero extension for loads, lane shift and mask generation for stores.

Verification
REQ-037 SW addr 0x104 data 0xDEADBEEF -> mask 1111, mem_addr 0x104, mem_data 0xDEADBEEF, o_done in cycle 3.
REQ-038 SB addr 0x103 data 0x000000A5 -> mask 1000, mem_data 0xA5000000; then LB 0x103 -> o_rdata 0xFFFFFFA5, LBU 0x103 -> 0x000000A5.
REQ-039 LH 0x102 with mem word 0x80017F00 -> o_rdata 0xFFFF8001; LHU -> 0x00008001.
REQ-040 LW 0x101 or LH 0x103 -> o_err next cycle, no o_mem_rd, o_busy stays 0.
REQ-041 Load with valid withheld, TIMEOUT=4 -> o_err after four WAIT cycles; valid on the fourth WAIT cycle -> o_done instead.
REQ-042 rst asserted in WAIT, then late i_mem_rd_valid -> no o_done, all outputs at reset values.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store memory port.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: store shift/mask plus legality check on the request side,
// lane extraction and sign/zero extension on the load-return side.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  i_st_funct3,
    input  logic        i_st_we,
    input  logic [1:0]  i_st_addr_lo,
    input  logic [31:0] i_st_wdata,
    output logic        o_illegal,
    output logic [3:0]  o_st_mask,
    output logic [31:0] o_st_data,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [31:0] i_ld_word,
    output logic [31:0] o_ld_data
);

    logic [3:0]  base_mask;
    logic [31:0] ld_lane;

    always_comb begin
        o_illegal = 1'b0;
        base_mask = 4'b0000;
        case (i_st_funct3)
            F3_B: base_mask = MASK_B;
            F3_H: begin
                base_mask = MASK_H;
                o_illegal = i_st_addr_lo[0];
            end
            F3_W: begin
                base_mask = MASK_W;
                o_illegal = |i_st_addr_lo;
            end
            // Unsigned variants only exist for loads.
            F3_BU: begin
                base_mask = MASK_B;
                o_illegal = i_st_we;
            end
            F3_HU: begin
                base_mask = MASK_H;
                o_illegal = i_st_we | i_st_addr_lo[0];
            end
            default: o_illegal = 1'b1;
        endcase
        o_st_mask = i_st_we ? (base_mask << i_st_addr_lo) : 4'b0000;
        o_st_data = i_st_wdata << {i_st_addr_lo, 3'b000};
    end

    always_comb begin
        ld_lane = i_ld_word >> {i_ld_addr_lo, 3'b000};
        case (i_ld_funct3)
            F3_B:    o_ld_data = {{24{ld_lane[7]}}, ld_lane[7:0]};
            F3_H:    o_ld_data = {{16{ld_lane[15]}}, ld_lane[15:0]};
            F3_BU:   o_ld_data = {24'h0, ld_lane[7:0]};
            F3_HU:   o_ld_data = {16'h0, ld_lane[15:0]};
            default: o_ld_data = ld_lane;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Single-outstanding load/store port between the core and a word-wide memory.
// state    | meaning
// IDLE     | accept a request; illegal/misaligned ones pulse o_err and stay here
// ISSUE    | one-cycle o_mem_rd or o_mem_wr strobe, timer loaded
// WAIT     | wait for the matching memory valid or timer terminal count
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_wrmask,
    output logic [31:0] o_mem_data,
    input  logic        i_mem_rd_valid,
    input  logic        i_mem_wr_valid,
    input  logic [31:0] i_mem_data
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

    lsu_state_e  state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_wrmask_q, mem_wrmask_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic [31:0] rdata_q, rdata_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;

    logic        illegal;
    logic [3:0]  st_mask;
    logic [31:0] st_data;
    logic [31:0] ld_data;
    logic        valid_hit;

    lsu_lane u_lane (
        .i_st_funct3  (i_funct3),
        .i_st_we      (i_we),
        .i_st_addr_lo (i_addr[1:0]),
        .i_st_wdata   (i_wdata),
        .o_illegal    (illegal),
        .o_st_mask    (st_mask),
        .o_st_data    (st_data),
        .i_ld_funct3  (funct3_q),
        .i_ld_addr_lo (addr_lo_q),
        .i_ld_word    (i_mem_data),
        .o_ld_data    (ld_data)
    );

    assign valid_hit = we_q ? i_mem_wr_valid : i_mem_rd_valid;

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        mem_rd_d     = 1'b0;
        mem_wr_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wrmask_d = mem_wrmask_q;
        mem_data_d   = mem_data_q;
        rdata_d      = rdata_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        addr_lo_d    = addr_lo_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else begin
                        state_d      = ST_ISSUE;
                        mem_rd_d     = ~i_we;
                        mem_wr_d     = i_we;
                        mem_addr_d   = {i_addr[31:2], 2'b00};
                        mem_wrmask_d = st_mask;
                        mem_data_d   = i_we ? st_data : 32'h0;
                        we_d         = i_we;
                        funct3_d     = i_funct3;
                        addr_lo_d    = i_addr[1:0];
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                tmr_d   = TMR_LOAD;
            end
            ST_WAIT: begin
                // A valid on the terminal-count cycle still wins over the timeout.
                if (valid_hit) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        rdata_d = ld_data;
                    end
                end else if (tmr_q == '0) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wrmask_q <= 4'b0000;
            mem_data_q   <= 32'h0;
            rdata_q      <= 32'h0;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            addr_lo_q    <= 2'b00;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wrmask_q <= mem_wrmask_d;
            mem_data_q   <= mem_data_d;
            rdata_q      <= rdata_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            addr_lo_q    <= addr_lo_d;
        end
    end

    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_err        = err_q;
    assign o_rdata      = rdata_q;
    assign o_mem_rd     = mem_rd_q;
    assign o_mem_wr     = mem_wr_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_wrmask = mem_wrmask_q;
    assign o_mem_data   = mem_data_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port; completions are checked against a queue of
// expected outcomes pushed as each request is driven.
module tb_lsu_mem_port;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_we;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr, i_wdata;
    logic        o_busy, o_done, o_err, o_mem_rd, o_mem_wr;
    logic [31:0] o_rdata, o_mem_addr, o_mem_data;
    logic [3:0]  o_mem_wrmask;
    logic        i_mem_rd_valid, i_mem_wr_valid;
    logic [31:0] i_mem_data;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] model_rdata = 32'h0;

    lsu_mem_port #(.TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_req          (i_req),
        .i_we           (i_we),
        .i_funct3       (i_funct3),
        .i_addr         (i_addr),
        .i_wdata        (i_wdata),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_rdata        (o_rdata),
        .o_err          (o_err),
        .o_mem_rd       (o_mem_rd),
        .o_mem_wr       (o_mem_wr),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wrmask   (o_mem_wrmask),
        .o_mem_data     (o_mem_data),
        .i_mem_rd_valid (i_mem_rd_valid),
        .i_mem_wr_valid (i_mem_wr_valid),
        .i_mem_data     (i_mem_data)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference load extension, written from byte/halfword selection.
    function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        int          idx;
        idx = 8 * int'(lo);
        b   = word[idx +: 8];
        h   = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return word;
        endcase
    endfunction

    // Advance to the next falling edge and retire any completion seen there.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (o_done === 1'b1 || o_err === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk32("unexpected_completion", {30'h0, o_done, o_err}, 32'h0);
            end else begin
                e = sb_q.pop_front();
                chk1("sb_err", o_err, e.err);
                chk1("sb_done", o_done, ~e.err);
                chk32("sb_rdata", o_rdata, e.rdata);
            end
        end
    endtask

    task automatic chk_reset(input string tag);
        chk1({tag, "_busy"}, o_busy, 1'b0);
        chk1({tag, "_done"}, o_done, 1'b0);
        chk1({tag, "_err"}, o_err, 1'b0);
        chk1({tag, "_mem_rd"}, o_mem_rd, 1'b0);
        chk1({tag, "_mem_wr"}, o_mem_wr, 1'b0);
        chk32({tag, "_wrmask"}, {28'h0, o_mem_wrmask}, 32'h0);
        chk32({tag, "_rdata"}, o_rdata, 32'h0);
        chk32({tag, "_mem_addr"}, o_mem_addr, 32'h0);
        chk32({tag, "_mem_data"}, o_mem_data, 32'h0);
    endtask

    // vcyc: WAIT cycle (1-based) carrying the matching valid; 0 withholds it.
    task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] mem_word, input int vcyc,
                       input logic [3:0] exp_mask, input logic [31:0] exp_mdata);
        exp_t        e;
        int          last;
        logic [31:0] exp_addr;
        last     = (vcyc == 0) ? TMO : vcyc;
        exp_addr = {addr[31:2], 2'b00};
        e.err    = (vcyc == 0);
        if (!e.err && !we) model_rdata = ld_model(f3, addr[1:0], mem_word);
        e.rdata = model_rdata;
        sb_q.push_back(e);

        i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
        tick();
        i_req = 1'b0;
        chk1({tag, "_issue_busy"}, o_busy, 1'b1);
        chk1({tag, "_issue_rd"}, o_mem_rd, ~we);
        chk1({tag, "_issue_wr"}, o_mem_wr, we);
        chk32({tag, "_issue_addr"}, o_mem_addr, exp_addr);
        chk32({tag, "_issue_mask"}, {28'h0, o_mem_wrmask}, {28'h0, exp_mask});
        if (we) chk32({tag, "_issue_data"}, o_mem_data, exp_mdata);

        for (int k = 1; k <= last; k++) begin
            tick();
            chk32({tag, "_wait_strobe"}, {30'h0, o_mem_rd, o_mem_wr}, 32'h0);
            chk1({tag, "_wait_busy"}, o_busy, 1'b1);
            chk32({tag, "_wait_addr"}, o_mem_addr, exp_addr);
            chk32({tag, "_wait_mask"}, {28'h0, o_mem_wrmask}, {28'h0, exp_mask});
            if (we) chk32({tag, "_wait_data"}, o_mem_data, exp_mdata);
            // Requests while busy carry a different address and must be dropped.
            i_req = (k < last);
            i_addr = 32'hFFFF_FFF0;
            i_mem_rd_valid = 1'b0; i_mem_wr_valid = 1'b0; i_mem_data = 32'h5555_5555;
            if (k == last && vcyc != 0) begin
                if (we) i_mem_wr_valid = 1'b1;
                else begin
                    i_mem_rd_valid = 1'b1;
                    i_mem_data = mem_word;
                end
            end else if (k == 1) begin
                if (we) i_mem_rd_valid = 1'b1;
                else    i_mem_wr_valid = 1'b1;
            end
        end
        tick();
        i_mem_rd_valid = 1'b0; i_mem_wr_valid = 1'b0; i_req = 1'b0;
        chk1({tag, "_end_done"}, o_done, ~e.err);
        chk1({tag, "_end_err"}, o_err, e.err);
        chk1({tag, "_end_busy"}, o_busy, 1'b0);
        tick();
        chk1({tag, "_post_done"}, o_done, 1'b0);
        chk1({tag, "_post_err"}, o_err, 1'b0);
        chk32({tag, "_post_rdata"}, o_rdata, model_rdata);
    endtask

    task automatic bad(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr);
        exp_t e;
        e.err = 1'b1;
        e.rdata = model_rdata;
        sb_q.push_back(e);
        i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = 32'h1234_5678;
        tick();
        i_req = 1'b0;
        chk1({tag, "_err"}, o_err, 1'b1);
        chk1({tag, "_busy"}, o_busy, 1'b0);
        chk32({tag, "_strobe"}, {30'h0, o_mem_rd, o_mem_wr}, 32'h0);
        tick();
        chk1({tag, "_err_clr"}, o_err, 1'b0);
        chk1({tag, "_busy2"}, o_busy, 1'b0);
        chk32({tag, "_strobe2"}, {30'h0, o_mem_rd, o_mem_wr}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i_req = 1'b0; i_we = 1'b0; i_funct3 = 3'b000;
        i_addr = 32'h0; i_wdata = 32'h0;
        i_mem_rd_valid = 1'b0; i_mem_wr_valid = 1'b0; i_mem_data = 32'h0;
        repeat (3) tick();
        chk_reset("reset");
        rst = 1'b0;
        tick();

        txn("sw_104",  1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 1, 4'b1111, 32'hDEAD_BEEF);
        txn("sb_103",  1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0, 2, 4'b1000, 32'hA500_0000);
        txn("lb_103",  1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'hA500_0000, 1, 4'b0000, 32'h0);
        txn("lbu_103", 1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'hA500_0000, 3, 4'b0000, 32'h0);
        txn("lh_102",  1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h8001_7F00, 1, 4'b0000, 32'h0);
        txn("lhu_102", 1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h8001_7F00, 2, 4'b0000, 32'h0);

        bad("lw_101",  1'b0, 3'b010, 32'h0000_0101);
        bad("lh_103",  1'b0, 3'b001, 32'h0000_0103);
        bad("sbu_100", 1'b1, 3'b100, 32'h0000_0100);
        bad("f3_011",  1'b0, 3'b011, 32'h0000_0100);
        bad("sw_102",  1'b1, 3'b010, 32'h0000_0102);

        txn("sh_102",  1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 32'h0, 1, 4'b1100, 32'h1234_0000);
        txn("lw_tc",   1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h1357_9BDF, TMO, 4'b0000, 32'h0);
        txn("lw_tmo",  1'b0, 3'b010, 32'h0000_0204, 32'h0, 32'hCAFE_0000, 0, 4'b0000, 32'h0);
        txn("lb_201",  1'b0, 3'b000, 32'h0000_0201, 32'h0, 32'h0000_8000, 1, 4'b0000, 32'h0);
        txn("sw_tmo",  1'b1, 3'b010, 32'h0000_0300, 32'h0BAD_F00D, 32'h0, 0, 4'b1111, 32'h0BAD_F00D);

        // Abort a load in WAIT; the late valid must be ignored.
        i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h0000_0400;
        tick();
        i_req = 1'b0;
        chk1("abort_issue_rd", o_mem_rd, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk_reset("abort_rst");
        rst = 1'b0;
        model_rdata = 32'h0;
        i_mem_rd_valid = 1'b1; i_mem_data = 32'hCAFE_F00D;
        tick();
        i_mem_rd_valid = 1'b0;
        tick();
        chk_reset("abort_late");
        tick();

        txn("lw_after", 1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'h8765_4321, 1, 4'b0000, 32'h0);

        chk32("sb_empty", sb_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
